// File: rtl/popcount_cfu.sv
// CFU-L0 population-count unit: combinational bit count of req_data0.
// Includes the shared CFU-LI constants package used by the CFU family.
package cfu_pkg;
  localparam int CFU_LI_VERSION = 1;
  localparam int CFU_STATUS_W   = 3;
  localparam logic [CFU_STATUS_W-1:0] CFU_OK    = 3'd0;
  localparam logic [CFU_STATUS_W-1:0] CFU_ERROR = 3'd1;
endpackage

module popcount_cfu
  import cfu_pkg::*;
#(
  parameter int CFU_LI_VERSION = cfu_pkg::CFU_LI_VERSION,
  parameter int CFU_N_CFUS     = 1,
  parameter int CFU_CFU_ID_W   = 0,
  parameter int CFU_FUNC_ID_W  = 0,
  parameter int CFU_DATA_W     = 32
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          req_valid,
  input  logic [((CFU_CFU_ID_W  > 0) ? CFU_CFU_ID_W  : 1)-1:0] req_cfu,
  input  logic [((CFU_FUNC_ID_W > 0) ? CFU_FUNC_ID_W : 1)-1:0] req_func,
  input  logic [CFU_DATA_W-1:0]                         req_data0,
  input  logic [CFU_DATA_W-1:0]                         req_data1,
  output logic [CFU_STATUS_W-1:0]                       resp_status,
  output logic [CFU_DATA_W-1:0]                         resp_data
);

  localparam int LVLS = $clog2(CFU_DATA_W);

  if (!(CFU_DATA_W == 32 || CFU_DATA_W == 64) || CFU_N_CFUS < 1) begin : g_bad_param
    $error("popcount_cfu: CFU_DATA_W must be 32 or 64 and CFU_N_CFUS >= 1");
  end

  // Level l holds CFU_DATA_W>>l partial counts, each l+1 bits wide, so the
  // root is LVLS+1 bits and can represent a fully-set operand without wrap.
  for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
    logic [l:0] sum [CFU_DATA_W >> l];
    for (genvar n = 0; n < (CFU_DATA_W >> l); n++) begin : g_node
      if (l == 1) begin : g_leaf
        assign sum[n] = {1'b0, req_data0[2*n]} + {1'b0, req_data0[2*n+1]};
      end else begin : g_add
        assign sum[n] = {1'b0, g_lvl[l-1].sum[2*n]} + {1'b0, g_lvl[l-1].sum[2*n+1]};
      end
    end
  end

  assign resp_data   = CFU_DATA_W'(g_lvl[LVLS].sum[0]);
  assign resp_status = CFU_OK;

  // Interface-compatibility inputs that the datapath intentionally ignores.
  logic unused_inputs;
  assign unused_inputs = ^{clk, rst, req_valid, req_cfu, req_func, req_data1,
                           CFU_LI_VERSION[0]};

endmodule

// File: tb/tb_popcount_cfu.sv
// Scoreboard bench for popcount_cfu: 32-bit (wide IDs) and 64-bit (default IDs) instances.
module tb_popcount_cfu;

  logic        clk = 1'b0;
  logic        rst;

  logic        v32;
  logic [1:0]  cfu32;
  logic [2:0]  func32;
  logic [31:0] a32, b32, r32;
  logic [2:0]  st32;

  logic        v64;
  logic [0:0]  cfu64, func64;
  logic [63:0] a64, b64, r64;
  logic [2:0]  st64;

  logic [63:0] exp32_q[$];
  logic [63:0] exp64_q[$];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  popcount_cfu #(
    .CFU_N_CFUS   (4),
    .CFU_CFU_ID_W (2),
    .CFU_FUNC_ID_W(3),
    .CFU_DATA_W   (32)
  ) u_dut32 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (v32),
    .req_cfu    (cfu32),
    .req_func   (func32),
    .req_data0  (a32),
    .req_data1  (b32),
    .resp_status(st32),
    .resp_data  (r32)
  );

  popcount_cfu #(
    .CFU_DATA_W(64)
  ) u_dut64 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (v64),
    .req_cfu    (cfu64),
    .req_func   (func64),
    .req_data0  (a64),
    .req_data1  (b64),
    .resp_status(st64),
    .resp_data  (r64)
  );

  function automatic logic [63:0] ref_pop(input logic [63:0] v);
    int unsigned c = 0;
    for (int i = 0; i < 64; i++) c += int'(v[i]);
    return 64'(c);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive32(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic [1:0] c, input logic v);
    a32 = a; b32 = b; func32 = f; cfu32 = c; v32 = v;
    exp32_q.push_back(ref_pop({32'h0, a}));
  endtask

  task automatic drive64(input logic [63:0] a, input logic [63:0] b, input logic v);
    a64 = a; b64 = b; v64 = v;
    func64 = 1'($urandom_range(0, 1));
    cfu64  = 1'($urandom_range(0, 1));
    exp64_q.push_back(ref_pop(a));
  endtask

  task automatic sample(input string tag);
    logic [63:0] e;
    @(negedge clk);
    if (exp32_q.size() > 0) begin
      e = exp32_q.pop_front();
      check({tag, "_d32"}, {32'h0, r32}, e);
      check({tag, "_s32"}, {61'h0, st32}, 64'd0);
    end
    if (exp64_q.size() > 0) begin
      e = exp64_q.pop_front();
      check({tag, "_d64"}, r64, e);
      check({tag, "_s64"}, {61'h0, st64}, 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] r;
    rst = 1'b0;
    drive32('0, '0, '0, '0, 1'b0);
    drive64('0, '0, 1'b0);
    exp32_q.delete();
    exp64_q.delete();
    @(posedge clk);
    #1;

    drive32(32'h0000_0000, 32'hFFFF_FFFF, 3'd0, 2'd0, 1'b1);
    drive64(64'h0, '1, 1'b1);
    sample("zero");

    drive32(32'hFFFF_FFFF, 32'h0, 3'd1, 2'd1, 1'b1);
    drive64('1, 64'h0, 1'b1);
    sample("ones");

    drive32(32'h8000_0001, 32'h1234_5678, 3'd2, 2'd3, 1'b1);
    drive64(64'h0000_0001_0000_0000, 64'h0, 1'b1);
    sample("edge");

    for (int f = 0; f < 8; f++) begin
      for (int v = 0; v < 2; v++) begin
        drive32(32'hA5A5_A5A5, $urandom(), 3'(f), 2'($urandom_range(0, 3)), 1'(v));
        drive64(64'hA5A5_A5A5_A5A5_A5A5, rand64(), 1'(v));
        sample("func");
      end
    end

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive32(32'h0000_000F, $urandom(), 3'(i), 2'(i), 1'b1);
      drive64(64'h0000_0000_0000_000F, rand64(), 1'b1);
      sample("rst");
    end
    rst = 1'b0;

    for (int i = 0; i < 10000; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       r = rand64() & rand64() & rand64();
        1:       r = rand64() | rand64() | rand64();
        default: r = rand64();
      endcase
      drive32(r[63:32], $urandom(), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
      drive64(r ^ {$urandom(), 32'h0}, rand64(), 1'($urandom_range(0, 1)));
      sample("rand");
    end
    rst = 1'b0;

    check("sb_empty32", 64'(exp32_q.size()), 64'd0);
    check("sb_empty64", 64'(exp64_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
